lsu_ctrl: RTL and testbench

Load/store sequencing controller in the MEM stage of the core. It receives the decoded load/store strobes and the `funct3` width field, then drives a request/grant/rvalid data-memory bus. It stalls the pipeline until the access completes and returns aligned, sign/zero-extended load data. It also flags misaligned or illegal accesses and bus timeouts.

---
 rtl/lsu_ctrl_if.sv | 38 +++
 rtl/lsu_ctrl.sv | 138 +++++++++++++
 tb/tb_lsu_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_ctrl_if.sv
// Pipeline and data-memory signals of the load/store controller.
// The master modport is the controller's view; slave is the pipeline/memory side.
interface lsu_ctrl_if;
  logic        i_valid;
  logic        i_load;
  logic        i_store;
  logic [2:0]  i_funct3;
  logic [31:0] i_addr;
  logic [31:0] i_wdata;
  logic        i_flush;
  logic        o_mem_req;
  logic        o_mem_we;
  logic [31:0] o_mem_addr;
  logic [3:0]  o_mem_be;
  logic [31:0] o_mem_wdata;
  logic        i_mem_gnt;
  logic        i_mem_rvalid;
  logic [31:0] i_mem_rdata;
  logic        o_stall;
  logic        o_done;
  logic [31:0] o_rdata;
  logic        o_misalign;
  logic        o_bus_err;

  modport master (
    input  i_valid, i_load, i_store, i_funct3, i_addr, i_wdata, i_flush,
    input  i_mem_gnt, i_mem_rvalid, i_mem_rdata,
    output o_mem_req, o_mem_we, o_mem_addr, o_mem_be, o_mem_wdata,
    output o_stall, o_done, o_rdata, o_misalign, o_bus_err
  );

  modport slave (
    output i_valid, i_load, i_store, i_funct3, i_addr, i_wdata, i_flush,
    output i_mem_gnt, i_mem_rvalid, i_mem_rdata,
    input  o_mem_req, o_mem_we, o_mem_addr, o_mem_be, o_mem_wdata,
    input  o_stall, o_done, o_rdata, o_misalign, o_bus_err
  );
endinterface

// File: rtl/lsu_ctrl.sv
// MEM-stage load/store sequencer: drives a req/gnt/rvalid bus, stalls until completion,
// returns extended load data and flags misaligned/illegal accesses and read timeouts.
module lsu_ctrl #(
  parameter int TIMEOUT = 255
) (
  input logic        i_clk,
  input logic        i_rst_n,
  lsu_ctrl_if.master bus
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  localparam logic [7:0] TO = TIMEOUT[7:0];

  state_t      state;
  logic [7:0]  cnt;
  logic        drop;
  logic [2:0]  f3_q;
  logic [1:0]  lane_q;

  logic        start, f3_ok, aligned, go, timeout_hit;
  logic [1:0]  size;
  logic [3:0]  be_c;
  logic [31:0] wdata_c, shifted, ext;

  always_comb begin
    size  = bus.i_funct3[1:0];
    start = (state == IDLE) & bus.i_valid & (bus.i_load | bus.i_store) & ~bus.i_flush;
    if (bus.i_store)
      f3_ok = ~bus.i_funct3[2] & (size != 2'b11);
    else
      f3_ok = (bus.i_funct3 != 3'b011) & (bus.i_funct3[2:1] != 2'b11);
    case (size)
      2'b01:   aligned = ~bus.i_addr[0];
      2'b10:   aligned = (bus.i_addr[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase
    go = start & f3_ok & aligned;

    case (size)
      2'b00: begin
        be_c    = 4'b0001 << bus.i_addr[1:0];
        wdata_c = {4{bus.i_wdata[7:0]}};
      end
      2'b01: begin
        be_c    = bus.i_addr[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{bus.i_wdata[15:0]}};
      end
      default: begin
        be_c    = 4'b1111;
        wdata_c = bus.i_wdata;
      end
    endcase

    // Lane select happens before extension so every width reads from bit 0.
    shifted = bus.i_mem_rdata >> {lane_q, 3'b000};
    case (f3_q)
      3'b000:  ext = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  ext = {24'd0, shifted[7:0]};
      3'b001:  ext = {{16{shifted[15]}}, shifted[15:0]};
      3'b101:  ext = {16'd0, shifted[15:0]};
      default: ext = bus.i_mem_rdata;
    endcase

    timeout_hit = (cnt >= TO - 8'd1);
  end

  assign bus.o_mem_req  = (state == REQ);
  assign bus.o_stall    = (state == REQ) | (state == WAIT) | go;
  assign bus.o_misalign = start & ~go;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state           <= IDLE;
      cnt             <= 8'd0;
      drop            <= 1'b0;
      f3_q            <= 3'd0;
      lane_q          <= 2'd0;
      bus.o_mem_we    <= 1'b0;
      bus.o_mem_addr  <= 32'd0;
      bus.o_mem_be    <= 4'd0;
      bus.o_mem_wdata <= 32'd0;
      bus.o_done      <= 1'b0;
      bus.o_rdata     <= 32'd0;
      bus.o_bus_err   <= 1'b0;
    end else begin
      bus.o_done    <= 1'b0;
      bus.o_bus_err <= 1'b0;
      case (state)
        IDLE: begin
          if (go) begin
            state           <= REQ;
            drop            <= 1'b0;
            f3_q            <= bus.i_funct3;
            lane_q          <= bus.i_addr[1:0];
            bus.o_mem_we    <= bus.i_store;
            bus.o_mem_addr  <= {bus.i_addr[31:2], 2'b00};
            bus.o_mem_be    <= be_c;
            bus.o_mem_wdata <= wdata_c;
          end
        end
        REQ: begin
          if (bus.i_mem_gnt) begin
            if (bus.o_mem_we) begin
              // A granted store is committed; a flush only suppresses the completion pulse.
              if (bus.i_flush) begin
                state <= IDLE;
              end else begin
                state      <= DONE;
                bus.o_done <= 1'b1;
              end
            end else begin
              state <= WAIT;
              cnt   <= 8'd0;
              drop  <= bus.i_flush;
            end
          end else if (bus.i_flush) begin
            state <= IDLE;
          end
        end
        WAIT: begin
          cnt <= (cnt == TO) ? cnt : cnt + 8'd1;
          if (bus.i_flush) drop <= 1'b1;
          if (bus.i_mem_rvalid || timeout_hit) begin
            if (drop || bus.i_flush) begin
              state <= IDLE;
            end else begin
              state         <= DONE;
              bus.o_done    <= 1'b1;
              bus.o_bus_err <= ~bus.i_mem_rvalid;
              bus.o_rdata   <= bus.i_mem_rvalid ? ext : 32'd0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_ctrl.sv
// Randomized scoreboard bench for lsu_ctrl with a width/lane arithmetic reference model.
module tb_lsu_ctrl;
  localparam int TIMEOUT = 4;

  typedef struct {
    int          kind;   // 0 misalign, 1 store done, 2 load done
    logic [31:0] rdata;
    logic        berr;
    int          stall;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } req_t;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_err    = 0;
  exp_t exp_q[$];
  req_t req_q[$];

  lsu_ctrl_if bus();

  lsu_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: widths in bytes and lane positions, plain arithmetic.
  function automatic bit is_legal(input bit st, input logic [2:0] f3, input logic [31:0] addr);
    int nb;
    bit ok;
    ok = st ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    nb = 1 << f3[1:0];
    return ok && ((addr % nb) == 0);
  endfunction

  function automatic logic [3:0] exp_be(input logic [2:0] f3, input logic [31:0] addr);
    int nb;
    nb = 1 << f3[1:0];
    return 4'((((1 << nb) - 1) << (addr % 4)));
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] r;
    int nb;
    nb = 1 << f3[1:0];
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % nb) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] exp_rdata(input logic [2:0] f3, input logic [31:0] addr,
                                            input logic [31:0] word);
    longint unsigned w, v, mask;
    int nb;
    nb   = 1 << f3[1:0];
    w    = longint'(word);
    mask = (64'd1 << (8 * nb)) - 64'd1;
    v    = (w >> (8 * (addr % 4))) & mask;
    if (!f3[2] && nb < 4 && ((v >> (8 * nb - 1)) & 64'd1) == 64'd1) v = v | ~mask;
    return v[31:0];
  endfunction

  task automatic idle_inputs();
    bus.i_valid      = 1'b0;
    bus.i_load       = 1'b0;
    bus.i_store      = 1'b0;
    bus.i_flush      = 1'b0;
    bus.i_mem_gnt    = 1'b0;
    bus.i_mem_rvalid = 1'b0;
  endtask

  // fm: 0 none, 1 flush in REQ before grant, 2 flush in first WAIT cycle, 3 flush with grant.
  // rw < 0 means the response never arrives.
  task automatic access(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input int gw, input int rw,
                        input logic [31:0] rd, input int fm);
    exp_t e;
    req_t r;
    @(posedge clk); #1;
    bus.i_valid  = 1'b1;
    bus.i_load   = !st;
    bus.i_store  = st;
    bus.i_funct3 = f3;
    bus.i_addr   = addr;
    bus.i_wdata  = wd;
    if (!is_legal(st, f3, addr)) begin
      e.kind = 0; e.rdata = 32'd0; e.berr = 1'b0; e.stall = 0;
      exp_q.push_back(e);
      @(posedge clk); #1;
      idle_inputs();
      return;
    end
    if (fm != 1) begin
      r.addr  = {addr[31:2], 2'b00};
      r.we    = st;
      r.be    = exp_be(f3, addr);
      r.wdata = exp_wdata(f3, wd);
      req_q.push_back(r);
    end
    if (fm == 0) begin
      e.kind  = st ? 1 : 2;
      e.berr  = !st && rw < 0;
      e.rdata = e.berr ? 32'd0 : exp_rdata(f3, addr, rd);
      e.stall = st ? 2 + gw : (rw < 0 ? 2 + gw + TIMEOUT : 3 + gw + rw);
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    idle_inputs();
    if (fm == 1) begin
      bus.i_flush = 1'b1;
      @(posedge clk); #1;
      bus.i_flush = 1'b0;
      chk("req_drop_after_flush", 32'(bus.o_mem_req), 32'd0);
      chk("stall_after_flush", 32'(bus.o_stall), 32'd0);
      return;
    end
    repeat (gw) begin @(posedge clk); #1; end
    bus.i_mem_gnt = 1'b1;
    bus.i_flush   = (fm == 3);
    @(posedge clk); #1;
    bus.i_mem_gnt = 1'b0;
    bus.i_flush   = 1'b0;
    if (!st) begin
      for (int c = 0; c < TIMEOUT; c++) begin
        bus.i_flush      = (fm == 2 && c == 0);
        bus.i_mem_rvalid = (c == rw);
        bus.i_mem_rdata  = (c == rw) ? rd : $urandom;
        @(posedge clk); #1;
        if (c == rw) break;
      end
      idle_inputs();
    end
    @(posedge clk); #1;
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a bus transfer or a result.
  initial begin : monitor
    int   stall_run;
    exp_t e;
    req_t r;
    stall_run = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_run = 0;
        continue;
      end
      if (bus.o_mem_req && bus.i_mem_gnt) begin
        if (req_q.size() == 0) begin
          chk("unexpected_mem_req", 32'(bus.o_mem_req), 32'd0);
        end else begin
          r = req_q.pop_front();
          chk("mem_addr", bus.o_mem_addr, r.addr);
          chk("mem_we", 32'(bus.o_mem_we), 32'(r.we));
          chk("mem_be", 32'(bus.o_mem_be), 32'(r.be));
          if (r.we) chk("mem_wdata", bus.o_mem_wdata, r.wdata);
        end
      end
      if (bus.o_misalign) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_misalign", 32'(bus.o_misalign), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("misalign_kind", 32'd0, 32'(e.kind));
          chk("misalign_no_stall", 32'(bus.o_stall), 32'd0);
          chk("misalign_no_req", 32'(bus.o_mem_req), 32'd0);
        end
      end
      if (bus.o_done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'(bus.o_done), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("done_kind", (bus.o_mem_we ? 32'd1 : 32'd2), 32'(e.kind));
          chk("stall_cycles", 32'(stall_run), 32'(e.stall));
          if (e.kind == 2) begin
            chk("load_rdata", bus.o_rdata, e.rdata);
            chk("bus_err", 32'(bus.o_bus_err), 32'(e.berr));
          end
        end
        stall_run = 0;
      end else if (bus.o_stall) begin
        stall_run++;
      end else begin
        stall_run = 0;
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bit          st;
    logic [2:0]  f3;
    logic [31:0] addr;
    int          gw, rw, fm, nb;
    logic [2:0]  lf [5];
    lf = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    rst_n = 1'b0;
    idle_inputs();
    bus.i_funct3    = 3'd0;
    bus.i_addr      = 32'd0;
    bus.i_wdata     = 32'd0;
    bus.i_mem_rdata = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_req", 32'(bus.o_mem_req), 32'd0);
    chk("rst_stall", 32'(bus.o_stall), 32'd0);
    chk("rst_done", 32'(bus.o_done), 32'd0);
    chk("rst_rdata", bus.o_rdata, 32'd0);
    chk("rst_bus_err", 32'(bus.o_bus_err), 32'd0);
    chk("rst_mem_be", 32'(bus.o_mem_be), 32'd0);
    rst_n = 1'b1;

    // Directed cases
    access(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, 32'h0, 0);
    access(1'b0, 3'b000, 32'h203, 32'h0, 2, 1, 32'h80112233, 0);
    access(1'b0, 3'b100, 32'h203, 32'h0, 2, 1, 32'h80112233, 0);
    access(1'b0, 3'b001, 32'h201, 32'h0, 0, 0, 32'h0, 0);
    access(1'b1, 3'b010, 32'h102, 32'h12345678, 0, 0, 32'h0, 0);
    access(1'b0, 3'b011, 32'h200, 32'h0, 0, 0, 32'h0, 0);
    access(1'b0, 3'b010, 32'h300, 32'h0, 0, -1, 32'h0, 0);
    access(1'b0, 3'b010, 32'h304, 32'h0, 0, 0, 32'hCAFEF00D, 0);
    access(1'b0, 3'b001, 32'h302, 32'h0, 1, 2, 32'h8001_7FFF, 0);
    access(1'b1, 3'b000, 32'h401, 32'h000000A5, 1, 0, 32'h0, 0);
    access(1'b1, 3'b001, 32'h402, 32'h0000BEEF, 0, 0, 32'h0, 0);
    access(1'b0, 3'b010, 32'h500, 32'h0, 2, 0, 32'h0, 1);
    access(1'b0, 3'b010, 32'h504, 32'h0, 0, 2, 32'h11111111, 2);
    access(1'b1, 3'b010, 32'h508, 32'h55AA55AA, 1, 0, 32'h0, 3);
    access(1'b0, 3'b101, 32'h50A, 32'h0, 0, 0, 32'h9876ABCD, 0);

    // Reset in the middle of WAIT; a late response afterwards must be ignored.
    @(posedge clk); #1;
    bus.i_valid = 1'b1; bus.i_load = 1'b1; bus.i_funct3 = 3'b010; bus.i_addr = 32'h600;
    req_q.push_back('{addr: 32'h600, we: 1'b0, be: 4'hF, wdata: 32'h0});
    @(posedge clk); #1;
    idle_inputs();
    bus.i_mem_gnt = 1'b1;
    @(posedge clk); #1;
    bus.i_mem_gnt = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_mem_req", 32'(bus.o_mem_req), 32'd0);
    chk("midrst_stall", 32'(bus.o_stall), 32'd0);
    chk("midrst_rdata", bus.o_rdata, 32'd0);
    chk("midrst_done", 32'(bus.o_done), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.i_mem_rvalid = 1'b1;
    bus.i_mem_rdata  = 32'hFFFFFFFF;
    @(posedge clk); #1;
    bus.i_mem_rvalid = 1'b0;
    chk("late_rvalid_stall", 32'(bus.o_stall), 32'd0);
    repeat (2) @(posedge clk);

    // Randomized traffic
    for (int n = 0; n < 120; n++) begin
      st = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) f3 = 3'($urandom_range(0, 7));
      else f3 = st ? 3'($urandom_range(0, 2)) : lf[$urandom_range(0, 4)];
      addr = $urandom;
      nb   = 1 << f3[1:0];
      if ($urandom_range(0, 3) != 0) addr = addr & ~32'(nb - 1);
      gw = $urandom_range(0, 3);
      rw = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, TIMEOUT - 1));
      fm = $urandom_range(0, 9);
      if (fm <= 6) fm = 0;
      else if (fm == 7) fm = 1;
      else if (fm == 8) fm = st ? 0 : 2;
      else fm = 3;
      if (fm == 1 && gw == 0) gw = 1;
      access(st, f3, addr, $urandom, gw, rw, $urandom, fm);
    end

    repeat (4) @(posedge clk);
    chk("exp_queue_drained", 32'(exp_q.size()), 32'd0);
    chk("req_queue_drained", 32'(req_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
